c0_sequencer: RTL and testbench

- Instruction fetch/decode/execute controller for the C0 core.
- Fetches a 24-bit instruction word from instruction memory at the core's instruction pointer, using a req/ack handshake.
- Decodes the word into the core's control lines and drives them for exactly one EXEC cycle per instruction.
- Sits between instruction ROM and the core. It replaces hand-driven control vectors.

---
 rtl/c0_ctrl_pkg.sv | 59 +++++
 rtl/c0_sequencer_if.sv | 13 +
 rtl/c0_instr_decode.sv | 66 ++++++
 rtl/c0_sequencer.sv | 137 +++++++++++++
 tb/tb_c0_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c0_ctrl_pkg.sv
// C0 sequencer shared definitions: instruction classes, SYS opcodes,
// MS codes, instruction field positions, FSM state codes, control vector.
package c0_ctrl_pkg;

  // Instruction classes, IR[23:22]
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MOV = 2'b01;
  localparam logic [1:0] CLS_JMP = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  // SYS opcodes, IR[21:18]
  localparam logic [3:0] SYS_NOP  = 4'h0;
  localparam logic [3:0] SYS_HALT = 4'h1;

  // Operand source codes driven on MS
  localparam logic [1:0] MS_ALU = 2'b00;
  localparam logic [1:0] MS_REG = 2'b01;
  localparam logic [1:0] MS_IMM = 2'b10;
  localparam logic [1:0] MS_MEM = 2'b11;

  // Instruction field bit positions
  localparam int unsigned CLS_HI    = 23;
  localparam int unsigned CLS_LO    = 22;
  localparam int unsigned OP_HI     = 21;
  localparam int unsigned OP_LO     = 18;
  localparam int unsigned MOV_MS_HI = 19;
  localparam int unsigned RD_HI     = 17;
  localparam int unsigned RD_LO     = 15;
  localparam int unsigned RA_HI     = 14;
  localparam int unsigned RA_LO     = 12;
  localparam int unsigned IRS_BIT   = 11;
  localparam int unsigned RB_HI     = 10;
  localparam int unsigned RB_LO     = 8;
  localparam int unsigned IMM_HI    = 7;
  localparam int unsigned IMM_LO    = 0;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  // Core control vector produced by decode
  typedef struct packed {
    logic       mem;
    logic       alu;
    logic       jmp;
    logic [1:0] ms;
    logic       irs;
    logic [2:0] rs;
    logic [2:0] ar;
    logic [2:0] bs;
    logic [3:0] op;
    logic [7:0] imm;
  } ctrl_t;

endpackage

// File: rtl/c0_sequencer_if.sv
// Instruction memory fetch port: req/ack handshake with address and data.
interface c0_sequencer_if #(
  parameter int unsigned IW = 24,
  parameter int unsigned AW = 8
);
  logic          IREQ;
  logic [AW-1:0] IADDR;
  logic          IACK;
  logic [IW-1:0] IDATA;

  modport master (output IREQ, output IADDR, input IACK, input IDATA);
  modport slave  (input IREQ, input IADDR, output IACK, output IDATA);
endinterface

// File: rtl/c0_instr_decode.sv
// Combinational decode of a 24-bit C0 instruction into the core control
// vector, with illegal-word and HALT flags.
module c0_instr_decode
  import c0_ctrl_pkg::*;
(
  input  logic [23:0] ir,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        halt
);

  logic [1:0] cls;
  logic [3:0] op;
  logic [1:0] mov_ms;

  assign cls    = ir[CLS_HI:CLS_LO];
  assign op     = ir[OP_HI:OP_LO];
  assign mov_ms = ir[MOV_MS_HI:OP_LO];

  // Per-class field mapping; anything not listed for a class stays zero
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    halt    = 1'b0;
    case (cls)
      CLS_ALU: begin
        ctrl.mem = 1'b1;
        ctrl.alu = 1'b1;
        ctrl.ms  = MS_ALU;
        ctrl.irs = ir[IRS_BIT];
        ctrl.op  = op;
        ctrl.rs  = ir[RD_HI:RD_LO];
        ctrl.ar  = ir[RA_HI:RA_LO];
        ctrl.bs  = ir[RB_HI:RB_LO];
        ctrl.imm = ir[IMM_HI:IMM_LO];
      end
      CLS_MOV: begin
        case (mov_ms)
          MS_REG, MS_IMM, MS_MEM: begin
            ctrl.mem = 1'b1;
            ctrl.ms  = mov_ms;
            ctrl.irs = (mov_ms == MS_IMM);
            ctrl.rs  = ir[RD_HI:RD_LO];
            ctrl.ar  = ir[RA_HI:RA_LO];
            ctrl.bs  = ir[RB_HI:RB_LO];
            ctrl.imm = ir[IMM_HI:IMM_LO];
          end
          default: illegal = 1'b1;
        endcase
      end
      CLS_JMP: begin
        ctrl.jmp = 1'b1;
        ctrl.op  = op;
        ctrl.imm = ir[IMM_HI:IMM_LO];
      end
      CLS_SYS: begin
        case (op)
          SYS_NOP:  halt = 1'b0;
          SYS_HALT: halt = 1'b1;
          default:  illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/c0_sequencer.sv
// C0 fetch/decode/execute sequencer: fetches an instruction at the core
// pointer, decodes it and drives the core control lines for one EXEC cycle.
module c0_sequencer
  import c0_ctrl_pkg::*;
#(
  parameter int unsigned IW      = 24,
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned RET_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RUN,
  input  logic             STEP,
  input  logic [AW-1:0]    CORE_ADDR,
  c0_sequencer_if.master   imem,
  output logic             MEM_INST,
  output logic             ALU_INST,
  output logic             JMP_INST,
  output logic [1:0]       MS,
  output logic             IRS,
  output logic [2:0]       RS,
  output logic [2:0]       AR,
  output logic [2:0]       BS,
  output logic [3:0]       OP,
  output logic [7:0]       IMM,
  output logic             BUSY,
  output logic             HALTED,
  output logic             FAULT,
  output logic [RET_W-1:0] RETIRED
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]       state;
  logic [IW-1:0]    ir;
  logic [CW-1:0]    wait_cnt;
  logic [AW-1:0]    iaddr;
  ctrl_t            shadow;
  ctrl_t            dec_ctrl;
  ctrl_t            exec_ctrl;
  logic             dec_illegal;
  logic             dec_halt;
  logic [RET_W-1:0] retired;

  c0_instr_decode u_decode (
    .ir      (ir),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .halt    (dec_halt)
  );

  // Main FSM: fetch handshake with timeout, decode into shadow, one-cycle exec
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      iaddr    <= '0;
      shadow   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (RUN || STEP) begin
            state    <= ST_FETCH;
            iaddr    <= CORE_ADDR;
            wait_cnt <= '0;
          end
        end
        ST_FETCH: begin
          if (imem.IACK) begin
            ir    <= imem.IDATA;
            state <= ST_DECODE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state <= ST_FAULT;
          end else if (dec_halt) begin
            state <= ST_HALT;
          end else begin
            shadow <= dec_ctrl;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (RUN) begin
            state    <= ST_FETCH;
            iaddr    <= CORE_ADDR;
            wait_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retired <= '0;
    end else if (state == ST_EXEC && retired != '1) begin
      retired <= retired + 1'b1;
    end
  end

  // Control lines carry the shadow only during EXEC so the core holds otherwise
  always_comb begin
    exec_ctrl = '0;
    if (state == ST_EXEC) exec_ctrl = shadow;
  end

  assign imem.IREQ  = (state == ST_FETCH);
  assign imem.IADDR = iaddr;

  assign MEM_INST = exec_ctrl.mem;
  assign ALU_INST = exec_ctrl.alu;
  assign JMP_INST = exec_ctrl.jmp;
  assign MS       = exec_ctrl.ms;
  assign IRS      = exec_ctrl.irs;
  assign RS       = exec_ctrl.rs;
  assign AR       = exec_ctrl.ar;
  assign BS       = exec_ctrl.bs;
  assign OP       = exec_ctrl.op;
  assign IMM      = exec_ctrl.imm;
  assign BUSY     = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
  assign HALTED   = (state == ST_HALT);
  assign FAULT    = (state == ST_FAULT);
  assign RETIRED  = retired;

endmodule

// File: tb/tb_c0_sequencer.sv
// Testbench for c0_sequencer: directed scenarios plus randomized legal
// instruction streams checked against an instruction-level reference model.
module tb_c0_sequencer;

  localparam int unsigned RET_W_TB = 4;
  localparam int unsigned RET_MAX  = (1 << RET_W_TB) - 1;

  logic                CLK;
  logic                RST_N;
  logic                RUN;
  logic                STEP;
  logic [7:0]          CORE_ADDR;
  logic                MEM_INST, ALU_INST, JMP_INST, IRS;
  logic [1:0]          MS;
  logic [2:0]          RS, AR, BS;
  logic [3:0]          OP;
  logic [7:0]          IMM;
  logic                BUSY, HALTED, FAULT;
  logic [RET_W_TB-1:0] RETIRED;
  logic [26:0]         ctrl_bus;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned model_ret;
  logic [7:0]  exp_addr;
  bit          running;

  c0_sequencer_if #(.IW(24), .AW(8)) imem_if ();

  c0_sequencer #(
    .IW      (24),
    .AW      (8),
    .TIMEOUT (15),
    .RET_W   (RET_W_TB)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RUN       (RUN),
    .STEP      (STEP),
    .CORE_ADDR (CORE_ADDR),
    .imem      (imem_if.master),
    .MEM_INST  (MEM_INST),
    .ALU_INST  (ALU_INST),
    .JMP_INST  (JMP_INST),
    .MS        (MS),
    .IRS       (IRS),
    .RS        (RS),
    .AR        (AR),
    .BS        (BS),
    .OP        (OP),
    .IMM       (IMM),
    .BUSY      (BUSY),
    .HALTED    (HALTED),
    .FAULT     (FAULT),
    .RETIRED   (RETIRED)
  );

  assign ctrl_bus = {MEM_INST, ALU_INST, JMP_INST, MS, IRS, RS, AR, BS, OP, IMM};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Reference: 0 = executes, 1 = halts, 2 = illegal
  function automatic int unsigned ref_kind(input logic [23:0] w);
    int unsigned wi, cls, op;
    wi  = int'(w);
    cls = wi / 4194304;
    op  = (wi / 262144) % 16;
    if (cls == 1 && (op % 4) == 0) return 2;
    if (cls == 3) begin
      if (op == 0) return 0;
      if (op == 1) return 1;
      return 2;
    end
    return 0;
  endfunction

  // Reference control vector {MEM,ALU,JMP,MS,IRS,RS,AR,BS,OP,IMM} during EXEC
  function automatic logic [26:0] ref_ctrl(input logic [23:0] w);
    int unsigned wi, cls, op, rd, ra, rb, ir_s, imm;
    int unsigned mem, alu, jmp, ms, irs, rs, ar, bs, opo, immo;
    wi   = int'(w);
    cls  = wi / 4194304;
    op   = (wi / 262144) % 16;
    rd   = (wi / 32768) % 8;
    ra   = (wi / 4096) % 8;
    ir_s = (wi / 2048) % 2;
    rb   = (wi / 256) % 8;
    imm  = wi % 256;
    mem = 0; alu = 0; jmp = 0; ms = 0; irs = 0; rs = 0; ar = 0; bs = 0; opo = 0; immo = 0;
    if (cls == 0) begin
      mem = 1; alu = 1; irs = ir_s; opo = op; rs = rd; ar = ra; bs = rb; immo = imm;
    end else if (cls == 1) begin
      mem = 1; ms = op % 4; irs = (ms == 2) ? 1 : 0; rs = rd; ar = ra; bs = rb; immo = imm;
    end else if (cls == 2) begin
      jmp = 1; opo = op; immo = imm;
    end
    return 27'(mem * (1 << 26) + alu * (1 << 25) + jmp * (1 << 24) + ms * (1 << 22) +
               irs * (1 << 21) + rs * (1 << 18) + ar * (1 << 15) + bs * (1 << 12) +
               opo * (1 << 8) + immo);
  endfunction

  function automatic logic [23:0] rand_legal();
    logic [23:0] w;
    w = 24'($urandom);
    if (w[23:22] == 2'b01 && w[19:18] == 2'b00) w[19:18] = 2'($urandom_range(1, 3));
    if (w[23:22] == 2'b11) w[21:18] = 4'h0;
    return w;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    RUN = 1'b0;
    STEP = 1'b0;
    imem_if.IACK = 1'b0;
    #1;
    chk("rst_ireq", imem_if.IREQ, 0);
    chk("rst_iaddr", imem_if.IADDR, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_retired", RETIRED, 0);
    chk("rst_ctrl", ctrl_bus, 0);
    model_ret = 0;
    running = 1'b0;
    cyc();
    RST_N = 1'b1;
  endtask

  // Start an instruction from IDLE by RUN or by a one-cycle STEP pulse
  task automatic launch(input bit use_step);
    exp_addr = 8'($urandom);
    CORE_ADDR = exp_addr;
    imem_if.IACK = 1'b0;
    if (use_step) begin
      STEP = 1'b1;
      cyc();
      STEP = 1'b0;
    end else begin
      RUN = 1'b1;
      cyc();
    end
  endtask

  // Carry one instruction from its first FETCH cycle through to completion
  task automatic do_instr(input logic [23:0] word, input int unsigned dly,
                          input bit run_after, input bit step_in_exec);
    int unsigned guard;
    int unsigned kind;
    guard = 0;
    while (imem_if.IREQ !== 1'b1 && guard < 8) begin
      cyc();
      guard++;
    end
    chk("fetch_ireq", imem_if.IREQ, 1);
    chk("fetch_iaddr", imem_if.IADDR, exp_addr);
    chk("fetch_ctrl", ctrl_bus, 0);
    RUN = run_after;
    imem_if.IACK = 1'b0;
    for (int unsigned i = 0; i < dly; i++) begin
      cyc();
      chk("wait_ireq", imem_if.IREQ, 1);
      chk("wait_iaddr", imem_if.IADDR, exp_addr);
    end
    imem_if.IACK = 1'b1;
    imem_if.IDATA = word;
    cyc();
    imem_if.IACK = 1'($urandom_range(0, 1));
    imem_if.IDATA = 24'($urandom);
    chk("dec_ireq", imem_if.IREQ, 0);
    chk("dec_busy", BUSY, 1);
    chk("dec_ctrl", ctrl_bus, 0);
    cyc();
    imem_if.IACK = 1'b0;
    kind = ref_kind(word);
    if (kind == 0) begin
      chk("exec_ctrl", ctrl_bus, ref_ctrl(word));
      chk("exec_busy", BUSY, 1);
      chk("exec_ireq", imem_if.IREQ, 0);
      chk("exec_ret", RETIRED, model_ret);
      if (model_ret < RET_MAX) model_ret++;
      if (step_in_exec) STEP = 1'b1;
      if (run_after) begin
        exp_addr = 8'($urandom);
        CORE_ADDR = exp_addr;
      end
      cyc();
      STEP = 1'b0;
      chk("post_ret", RETIRED, model_ret);
      chk("post_ctrl", ctrl_bus, 0);
      chk("post_ireq", imem_if.IREQ, run_after);
      if (!run_after) begin
        for (int unsigned i = 0; i < 2; i++) begin
          imem_if.IACK = 1'($urandom_range(0, 1));
          cyc();
          chk("idle_ireq", imem_if.IREQ, 0);
          chk("idle_busy", BUSY, 0);
        end
        imem_if.IACK = 1'b0;
      end
      running = run_after;
    end else begin
      chk("stop_halted", HALTED, (kind == 1) ? 1 : 0);
      chk("stop_fault", FAULT, (kind == 2) ? 1 : 0);
      chk("stop_busy", BUSY, 0);
      chk("stop_ireq", imem_if.IREQ, 0);
      chk("stop_ctrl", ctrl_bus, 0);
      chk("stop_ret", RETIRED, model_ret);
      running = 1'b0;
    end
  endtask

  initial begin
    int unsigned guard;
    bit          ra;
    n_cmp = 0;
    n_err = 0;
    model_ret = 0;
    running = 1'b0;
    exp_addr = '0;
    RST_N = 1'b1;
    RUN = 1'b0;
    STEP = 1'b0;
    CORE_ADDR = '0;
    imem_if.IACK = 1'b0;
    imem_if.IDATA = '0;
    @(posedge CLK);
    #1;
    do_reset();

    // Directed: MOV #imm, ADD, JMP with address recapture, then stop
    launch(1'b0);
    do_instr(24'h480005, 0, 1'b1, 1'b0);
    do_instr(24'h000100, 2, 1'b1, 1'b0);
    do_instr(24'h9C0000, 1, 1'b1, 1'b0);
    do_instr(24'h000100, 0, 1'b0, 1'b0);

    // Single step with a second STEP pulse during EXEC
    launch(1'b1);
    do_instr(24'h000100, 0, 1'b0, 1'b1);

    // HALT is terminal and does not retire
    launch(1'b0);
    do_instr(24'hC40000, 1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      RUN = 1'b1;
      STEP = 1'($urandom_range(0, 1));
      imem_if.IACK = 1'($urandom_range(0, 1));
      cyc();
      chk("halt_ireq", imem_if.IREQ, 0);
      chk("halt_halted", HALTED, 1);
      chk("halt_ret", RETIRED, model_ret);
    end
    do_reset();

    // Random legal stream, long enough to saturate the retired counter
    for (int unsigned i = 0; i < 40; i++) begin
      if (!running) launch(1'($urandom_range(0, 1)));
      ra = (i == 39) ? 1'b0 : ($urandom_range(0, 3) != 0);
      do_instr(rand_legal(), $urandom_range(0, 4), ra, 1'($urandom_range(0, 1)));
    end

    // Illegal MOV source
    launch(1'b0);
    do_instr(24'h400000, 0, 1'b0, 1'b0);
    do_reset();

    // Fetch timeout
    launch(1'b0);
    chk("to_ireq_on", imem_if.IREQ, 1);
    guard = 0;
    while (FAULT !== 1'b1 && guard < 40) begin
      cyc();
      guard++;
    end
    chk("to_cycles", guard, 15);
    chk("to_ireq_off", imem_if.IREQ, 0);
    chk("to_busy", BUSY, 0);
    do_reset();

    // Reset during FETCH drops IREQ at once
    launch(1'b0);
    chk("midfetch_ireq", imem_if.IREQ, 1);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
